// File: rtl/load_extend_if.sv
// ---------------------------------------------------------------------------
// load_extend_if
//   Bundles the load-extend stream: the input beat (raw memory word plus
//   offset/size/signedness), the extended output beat and the saturating
//   misalignment counter.
//   master : producer of input beats / consumer of output beats
//   slave  : the load_extend_pipe block
// Signals
//   in_valid/in_ready      input handshake
//   in_data   [DATA_W]     raw memory word
//   in_offset [OFF_W]      byte offset within the word
//   in_size   [2]          0=byte 1=half 2=word 3=reserved (word)
//   in_unsigned            1=zero-extend 0=sign-extend
//   out_valid/out_ready    output handshake
//   out_data  [DATA_W]     extended result (0 when misaligned)
//   out_misalign           beat was misaligned
//   err_count [CNT_W]      saturating count of accepted misaligned beats
// ---------------------------------------------------------------------------
interface load_extend_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_offset;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_misalign;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output in_valid, in_data, in_offset, in_size, in_unsigned, out_ready,
    input  in_ready, out_valid, out_data, out_misalign, err_count
  );

  modport slave (
    input  in_valid, in_data, in_offset, in_size, in_unsigned, out_ready,
    output in_ready, out_valid, out_data, out_misalign, err_count
  );
endinterface

// File: rtl/load_extend_pipe.sv
// ---------------------------------------------------------------------------
// load_extend_pipe
//   Pipelined load extender between data memory and register writeback.
//   Extracts byte/half/word from the memory word at the given byte offset,
//   sign- or zero-extends it to DATA_W, and flags misaligned accesses
//   (result forced to 0). One output register plus a one-entry skid buffer
//   give 1-cycle latency and full throughput with a registered in_ready.
// Ports
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   load_extend_if.slave (input/output handshakes, err_count)
// ---------------------------------------------------------------------------
module load_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  load_extend_if.slave  bus
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  // Returns {misalign, extended_data} for one input beat.
  function automatic logic [DATA_W:0] extend_beat(
    input logic [DATA_W-1:0] data,
    input logic [OFF_W-1:0]  off,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic              mis;
    logic [DATA_W-1:0] res;
    b = data[{off, 3'b000} +: 8];
    // Half select ignores off[0]; alignment is checked separately.
    h = data[{off[OFF_W-1:1], 4'b0000} +: 16];
    case (size)
      2'd0: begin
        mis = 1'b0;
        res = uns ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
      end
      2'd1: begin
        mis = off[0];
        res = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
      end
      default: begin
        // Word and reserved size: whole word, must be word-aligned.
        mis = (off != {OFF_W{1'b0}});
        res = data;
      end
    endcase
    if (mis) begin
      res = {DATA_W{1'b0}};
    end else begin
      res = res;
    end
    return {mis, res};
  endfunction

  logic [DATA_W:0]   w_beat;
  logic              w_in_fire;
  logic              w_out_free;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_mis;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_mis;
  logic              r_in_ready;
  logic [CNT_W-1:0]  r_err_count;

  // Combinational extraction/extension of the incoming beat.
  always_comb begin
    w_beat     = extend_beat(bus.in_data, bus.in_offset, bus.in_size, bus.in_unsigned);
    w_in_fire  = bus.in_valid & r_in_ready;
    // Output register can take a new beat this cycle.
    w_out_free = ~r_out_valid | bus.out_ready;
  end

  // Output register and skid buffer; in_ready mirrors !skid_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= {DATA_W{1'b0}};
      r_out_mis    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= {DATA_W{1'b0}};
      r_skid_mis   <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      if (w_out_free) begin
        // Skid holds the older beat, so it goes first. No input can fire
        // while skid is full because in_ready is low.
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_out_mis    <= r_skid_mis;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else if (w_in_fire) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= w_beat[DATA_W-1:0];
          r_out_mis    <= w_beat[DATA_W];
        end else begin
          r_out_valid  <= 1'b0;
        end
      end else begin
        // Output stalled: park the accepted beat in skid.
        if (w_in_fire) begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= w_beat[DATA_W-1:0];
          r_skid_mis   <= w_beat[DATA_W];
          r_in_ready   <= 1'b0;
        end else begin
          r_skid_valid <= r_skid_valid;
        end
      end
    end
  end

  // Saturating count of accepted misaligned beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= {CNT_W{1'b0}};
    end else if (w_in_fire && w_beat[DATA_W] && (r_err_count != {CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_misalign = r_out_mis;
  assign bus.err_count    = r_err_count;
endmodule
